flash_pp_wr: RTL and testbench
==============================

// Module: flash_pp_wr
// PURPOSE
//  SPI NOR flash page-program writer, companion to the flash read path on the same SPI bus.
//  On start: sends WREN (0x06), then PAGE PROGRAM (0x02) + 24-bit address + N data bytes
//  pulled from a valid/ready byte stream, then polls RDSR (0x05) until WIP clears.
//  Sits between the data source (UART/FIFO) and the flash pins; shares the SPI mode-0 timing
//  used by the read path: SCK = clk/4, MSB first.
// PARAMETERS
//  CS_GAP    8        clk cycles cs_n held high between WREN, PP and RDSR transactions (>=2)
//  POLL_MAX  32'd2_000_000  max status bytes read before timeout error
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous reset, active-low
//  start      in   1   1-cycle pulse; sampled only in IDLE
//  addr       in   24  flash byte address, latched on start
//  byte_num   in   9   bytes to program, 1..256, latched on start
//  din        in   8   write data byte
//  din_valid  in   1   din holds a valid byte
//  din_ready  out  1   block accepts din this cycle (transfer = din_valid & din_ready)
//  miso       in   1   flash serial data out
//  cs_n       out  1   flash chip select, active-low
//  sck        out  1   SPI clock, idle low (mode 0)
//  mosi       out  1   SPI data to flash
//  busy       out  1   high from the cycle after accepted start until done
//  done       out  1   1-cycle pulse at end of operation (success or error)
//  err        out  1   valid with done: 1 = rejected parameters or poll timeout
// BEHAVIOUR
//  Reset: cs_n=1, sck=0, mosi=0, din_ready=0, busy=0, done=0, err=0, FSM=IDLE, counters 0.
//  Reset mid-operation aborts immediately; cs_n goes high asynchronously; no resume.
//  Bit timing: 2-bit sck_cnt runs while a byte is active. mosi updates at sck_cnt==0.
//   sck is driven 1 at sck_cnt==1 and 0 at sck_cnt==3. miso is sampled at sck_cnt==2.
//   One byte takes 32 clk. cs_n falls >=1 clk before the first sck rise.
//   cs_n rises >=2 clk after the last sck fall.
//  FSM: IDLE -> CHK -> WREN -> GAP1 -> PP_HDR -> PP_DATA -> GAP2 -> POLL -> DONE -> IDLE.
//   CHK (1 clk): err path if byte_num==0 or byte_num>256 or addr[7:0]+byte_num>256
//     (page crossing). On error go to DONE with err=1; no SPI activity occurs.
//   WREN: a single byte 0x06 in its own cs_n frame.
//   GAP1/GAP2: cs_n high for CS_GAP clk.
//   PP_HDR: bytes 0x02, addr[23:16], addr[15:8], addr[7:0].
//   PP_DATA: byte_num data bytes, then end the cs_n frame.
//   POLL: 0x05, then status bytes are clocked continuously in one frame. After each status
//     byte, if bit0 (WIP)==0, end the frame and go to DONE with err=0. After POLL_MAX status
//     bytes with WIP still set, end the frame and go to DONE with err=1.
//   DONE: done=1 for 1 clk, busy falls in the same cycle.
//  Data handshake: din_ready=1 only in PP_DATA when the shift register is empty. That is the
//   first PP_DATA cycle and after the 8th bit of each byte, while bytes remain.
//   A byte is loaded on din_valid&din_ready.
//   If din_valid is low at a byte boundary, sck holds 0, cs_n stays 0 and mosi holds.
//   Shifting resumes at sck_cnt==0 the cycle after the load.
//   Never more than byte_num bytes are accepted; din_ready is 0 in every other state.
//  start while busy is ignored. start and reset together: reset wins.
//  Byte counter is 9 bit, no wrap; poll counter is 32 bit, saturating compare to POLL_MAX.
// STRUCTURE
//  Package flash_spi_pkg: opcodes RD=8'h03, WREN=8'h06, PP=8'h02, RDSR=8'h05, WIP_BIT=0,
//   state encodings. Shared with the flash read path.
//  Sub-module spi_byte_shift: load/shift 8-bit mode-0 engine with sck/mosi/miso sampling
//   and byte_done pulse. Reusable by the read path. The FSM and counters stay in flash_pp_wr.
// TESTING (bench with SPI flash behavioural model checking opcodes/timing)
//  1. start, addr=24'h00_01_00, byte_num=4, din 11,22,33,44 always valid
//     -> frames 06 | 02 00 01 00 11 22 33 44 | 05 + status; model WIP 3 polls
//     -> done=1, err=0, busy low.
//  2. Same as 1, but din_valid drops for 50 clk before byte 3
//     -> sck low and cs_n low throughout the stall; data in flash unchanged from case 1.
//  3. byte_num=0, then addr[7:0]=8'hF0 with byte_num=32
//     -> done=1, err=1 within 3 clk; cs_n never falls.
//  4. byte_num=256, addr=24'h12_34_00 -> 256 handshakes exactly; 260 bytes in the PP frame.
//  5. Model holds WIP=1 forever, POLL_MAX=4 -> 4 status bytes, cs_n rises, done=1, err=1.
//  6. rst_n low mid PP_DATA -> cs_n=1, sck=0, busy=0 at once. New start runs a clean case 1.

Source files
------------

// File: rtl/flash_spi_pkg.sv
// ---------------------------------------------------------------------------
// flash_spi_pkg
// Shared definitions for the SPI NOR flash read and page-program paths:
// command opcodes, status register bit positions, the page-program FSM
// state encoding and the page-program parameter check.
// ---------------------------------------------------------------------------
package flash_spi_pkg;

    localparam logic [7:0] OP_RD   = 8'h03;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;

    localparam int         WIP_BIT  = 0;
    localparam logic [7:0] WIP_MASK = 8'(1 << WIP_BIT);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHK,
        ST_WREN,
        ST_GAP1,
        ST_PP_HDR,
        ST_PP_DATA,
        ST_GAP2,
        ST_POLL,
        ST_DONE
    } pp_state_t;

    // A page program must carry 1..256 bytes and must not run past the end
    // of the 256-byte page that contains the start address.
    function automatic logic pp_params_bad(input logic [7:0] addr_lo,
                                           input logic [8:0] num);
        logic [9:0] end_off;
        end_off = {2'b00, addr_lo} + {1'b0, num};
        return (num == 9'd0) || (num > 9'd256) || (end_off > 10'd256);
    endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// ---------------------------------------------------------------------------
// spi_byte_shift
// One-byte SPI mode-0 shift engine, MSB first, SCK = clk/4.
// A byte is started by pulsing load while the engine is idle. Each bit takes
// four clk: mosi changes at phase 0, sck rises at phase 1, miso is sampled at
// phase 2, sck falls at phase 3. byte_done pulses for one clk after the last
// sck fall, at which point rx_byte holds the received byte and the engine is
// idle again (sck low, mosi holding its last value).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         start a byte (ignored while active)
//   tx_byte      byte to transmit, captured on load
//   miso         serial input from flash
//   sck, mosi    serial clock / data to flash
//   active       a byte is being shifted
//   byte_done    1-clk pulse after the 8th bit
//   rx_byte      byte received during the last transfer
// ---------------------------------------------------------------------------
module spi_byte_shift (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       active,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    logic [1:0] sck_cnt_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] tx_sh_reg;
    logic [7:0] rx_sh_reg;
    logic       active_reg;
    logic       sck_reg;
    logic       mosi_reg;
    logic       done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_cnt_reg <= 2'd0;
            bit_cnt_reg <= 3'd0;
            tx_sh_reg   <= 8'h00;
            rx_sh_reg   <= 8'h00;
            active_reg  <= 1'b0;
            sck_reg     <= 1'b0;
            mosi_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!active_reg) begin
                if (load) begin
                    tx_sh_reg   <= tx_byte;
                    active_reg  <= 1'b1;
                    sck_cnt_reg <= 2'd0;
                    bit_cnt_reg <= 3'd0;
                end
            end else begin
                sck_cnt_reg <= sck_cnt_reg + 2'd1;
                case (sck_cnt_reg)
                    2'd0: mosi_reg  <= tx_sh_reg[7];
                    2'd1: sck_reg   <= 1'b1;
                    2'd2: rx_sh_reg <= {rx_sh_reg[6:0], miso};
                    default: begin
                        sck_reg     <= 1'b0;
                        tx_sh_reg   <= {tx_sh_reg[6:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            active_reg <= 1'b0;
                            done_reg   <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign sck       = sck_reg;
    assign mosi      = mosi_reg;
    assign active    = active_reg;
    assign byte_done = done_reg;
    assign rx_byte   = rx_sh_reg;

endmodule

// File: rtl/flash_pp_wr.sv
// ---------------------------------------------------------------------------
// flash_pp_wr
// SPI NOR flash page-program writer. On start it issues WREN, then a
// PAGE PROGRAM frame (opcode, 24-bit address, byte_num data bytes taken
// from a valid/ready byte stream), then reads the status register in one
// continuous RDSR frame until WIP clears or POLL_MAX status bytes have been
// read. Parameters that are out of range or cross a page are rejected
// before any SPI activity.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  1-clk start pulse, sampled in IDLE only
//   addr[23:0]             flash byte address (latched on start)
//   byte_num[8:0]          bytes to program, 1..256 (latched on start)
//   din, din_valid         data byte stream in
//   din_ready              stream handshake (transfer = valid & ready)
//   miso                   flash serial output
//   cs_n, sck, mosi        flash SPI pins
//   busy                   operation in progress
//   done                   1-clk end-of-operation pulse
//   err                    with done: parameter reject or poll timeout
// ---------------------------------------------------------------------------
module flash_pp_wr
    import flash_spi_pkg::*;
#(
    parameter int          CS_GAP   = 8,
    parameter logic [31:0] POLL_MAX = 32'd2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] addr,
    input  logic [8:0]  byte_num,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        miso,
    output logic        cs_n,
    output logic        sck,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int          GW      = $clog2(CS_GAP + 1);
    localparam logic [GW-1:0] GAP_END = GW'(CS_GAP);

    pp_state_t      state_reg;
    logic [23:0]    addr_reg;
    logic [8:0]     num_reg;
    logic [8:0]     data_cnt_reg;
    logic [1:0]     hdr_idx_reg;
    logic [GW-1:0]  gap_cnt_reg;
    logic [31:0]    poll_cnt_reg;
    logic           poll_first_reg;
    logic           poll_end_reg;
    logic           cs_n_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           err_reg;

    logic           eng_load;
    logic [7:0]     eng_tx;
    logic           eng_active;
    logic           eng_done;
    logic [7:0]     eng_rx;

    logic           din_ready_int;
    logic           params_bad;
    logic [7:0]     hdr_next;
    logic           status_clear;
    logic           poll_last;

    spi_byte_shift u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (eng_load),
        .tx_byte   (eng_tx),
        .miso      (miso),
        .sck       (sck),
        .mosi      (mosi),
        .active    (eng_active),
        .byte_done (eng_done),
        .rx_byte   (eng_rx)
    );

    // Byte loads are decided combinationally so the next byte of a frame
    // starts in the cycle right after byte_done.
    always_comb begin
        eng_load      = 1'b0;
        eng_tx        = 8'h00;
        params_bad    = pp_params_bad(addr_reg[7:0], num_reg);
        status_clear  = ((eng_rx & WIP_MASK) == 8'h00);
        poll_last     = (({1'b0, poll_cnt_reg} + 33'd1) >= {1'b0, POLL_MAX});
        din_ready_int = (state_reg == ST_PP_DATA) && !eng_active &&
                        (data_cnt_reg != num_reg);
        case (hdr_idx_reg)
            2'd0:    hdr_next = addr_reg[23:16];
            2'd1:    hdr_next = addr_reg[15:8];
            default: hdr_next = addr_reg[7:0];
        endcase

        case (state_reg)
            ST_CHK: begin
                if (!params_bad) begin
                    eng_load = 1'b1;
                    eng_tx   = OP_WREN;
                end
            end
            ST_GAP1: begin
                if (gap_cnt_reg == GAP_END) begin
                    eng_load = 1'b1;
                    eng_tx   = OP_PP;
                end
            end
            ST_PP_HDR: begin
                if (eng_done && hdr_idx_reg != 2'd3) begin
                    eng_load = 1'b1;
                    eng_tx   = hdr_next;
                end
            end
            ST_PP_DATA: begin
                if (din_valid && din_ready_int) begin
                    eng_load = 1'b1;
                    eng_tx   = din;
                end
            end
            ST_GAP2: begin
                if (gap_cnt_reg == GAP_END) begin
                    eng_load = 1'b1;
                    eng_tx   = OP_RDSR;
                end
            end
            ST_POLL: begin
                // After the opcode, keep clocking dummy bytes while the
                // flash still reports WIP and the poll budget is not spent.
                if (eng_done && !poll_end_reg &&
                    (poll_first_reg || (!status_clear && !poll_last))) begin
                    eng_load = 1'b1;
                    eng_tx   = 8'h00;
                end
            end
            default: begin
                eng_load = 1'b0;
            end
        endcase
    end

    // Gap states: cs_n stays low for 2 clk after the last sck fall, then
    // high for CS_GAP clk; the next frame's first byte is loaded together
    // with the cs_n fall so cs_n leads the first sck rise by 2 clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= 24'h000000;
            num_reg        <= 9'd0;
            data_cnt_reg   <= 9'd0;
            hdr_idx_reg    <= 2'd0;
            gap_cnt_reg    <= '0;
            poll_cnt_reg   <= 32'd0;
            poll_first_reg <= 1'b0;
            poll_end_reg   <= 1'b0;
            cs_n_reg       <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        addr_reg  <= addr;
                        num_reg   <= byte_num;
                        busy_reg  <= 1'b1;
                        err_reg   <= 1'b0;
                        state_reg <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (params_bad) begin
                        err_reg   <= 1'b1;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_DONE;
                    end else begin
                        cs_n_reg  <= 1'b0;
                        state_reg <= ST_WREN;
                    end
                end
                ST_WREN: begin
                    if (eng_done) begin
                        gap_cnt_reg <= '0;
                        state_reg   <= ST_GAP1;
                    end
                end
                ST_GAP1: begin
                    gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    if (gap_cnt_reg == '0) begin
                        cs_n_reg <= 1'b1;
                    end
                    if (gap_cnt_reg == GAP_END) begin
                        cs_n_reg    <= 1'b0;
                        hdr_idx_reg <= 2'd0;
                        state_reg   <= ST_PP_HDR;
                    end
                end
                ST_PP_HDR: begin
                    if (eng_done) begin
                        if (hdr_idx_reg == 2'd3) begin
                            data_cnt_reg <= 9'd0;
                            state_reg    <= ST_PP_DATA;
                        end else begin
                            hdr_idx_reg <= hdr_idx_reg + 2'd1;
                        end
                    end
                end
                ST_PP_DATA: begin
                    if (eng_load) begin
                        data_cnt_reg <= data_cnt_reg + 9'd1;
                    end else if (!eng_active && data_cnt_reg == num_reg) begin
                        gap_cnt_reg <= '0;
                        state_reg   <= ST_GAP2;
                    end
                end
                ST_GAP2: begin
                    gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    if (gap_cnt_reg == '0) begin
                        cs_n_reg <= 1'b1;
                    end
                    if (gap_cnt_reg == GAP_END) begin
                        cs_n_reg       <= 1'b0;
                        poll_cnt_reg   <= 32'd0;
                        poll_first_reg <= 1'b1;
                        poll_end_reg   <= 1'b0;
                        state_reg      <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    if (poll_end_reg) begin
                        // One extra clk after byte_done gives the 2-clk
                        // sck-fall to cs_n-rise spacing.
                        cs_n_reg  <= 1'b1;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_DONE;
                    end else if (eng_done) begin
                        if (poll_first_reg) begin
                            poll_first_reg <= 1'b0;
                        end else begin
                            if (poll_cnt_reg < POLL_MAX) begin
                                poll_cnt_reg <= poll_cnt_reg + 32'd1;
                            end
                            if (status_clear) begin
                                err_reg      <= 1'b0;
                                poll_end_reg <= 1'b1;
                            end else if (poll_last) begin
                                err_reg      <= 1'b1;
                                poll_end_reg <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign din_ready = din_ready_int;
    assign cs_n      = cs_n_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_flash_pp_wr.sv
// ---------------------------------------------------------------------------
// tb_flash_pp_wr
// Bench for flash_pp_wr with a behavioural SPI flash (WEL, page program,
// status register with a programmable number of WIP-busy reads). Each
// operation pushes its expected frames and done/err result into queues;
// the flash model and a done monitor pop and compare as the DUT produces
// them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_flash_pp_wr;

    localparam int CS_GAP   = 8;
    localparam int POLL_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [8:0]  byte_num = 9'd0;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic        miso = 1'b0;
    logic        din_ready, cs_n, sck, mosi, busy, done, err;

    always #5 clk = ~clk;

    flash_pp_wr #(.CS_GAP(CS_GAP), .POLL_MAX(32'd4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .byte_num(byte_num),
        .din(din), .din_valid(din_valid), .din_ready(din_ready), .miso(miso),
        .cs_n(cs_n), .sck(sck), .mosi(mosi), .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    int         exp_flen[$];
    int         exp_ncmp[$];
    logic [7:0] exp_bytes[$];
    bit         exp_err_q[$];
    logic [7:0] tx_data[$];
    logic [7:0] ref_mem[int];

    // ---------------- flash behavioural model ----------------
    longint     cyc = 0;
    longint     cs_fall_cyc = 0;
    longint     cs_rise_cyc = -1000;
    longint     sck_fall_cyc = 0;
    int         nbits = 0;
    logic [7:0] cur = 8'h00;
    logic [7:0] fb[$];
    bit         wel = 1'b0;
    bit         frame_open = 1'b0;
    bit         ignore_frame = 1'b0;
    int         wip_polls = 0;
    int         frames_opened = 0;
    logic [7:0] fmem[int];

    always @(posedge clk) cyc++;

    always @(negedge cs_n) begin
        if (rst_n) begin
            check("cs_gap", (cyc - cs_rise_cyc) >= CS_GAP, cyc - cs_rise_cyc, CS_GAP);
            frames_opened++;
            frame_open = 1'b1;
            nbits = 0;
            fb.delete();
            cs_fall_cyc = cyc;
            miso = 1'b0;
        end
    end

    always @(posedge sck) begin
        if (frame_open) begin
            if (nbits == 0)
                check("cs_setup", (cyc - cs_fall_cyc) >= 1, cyc - cs_fall_cyc, 1);
            cur = {cur[6:0], mosi};
            nbits++;
            if (nbits % 8 == 0) fb.push_back(cur);
        end else begin
            check("sck_outside_frame", 1'b0, cs_n, 0);
        end
    end

    always @(negedge sck) begin
        int idx;
        logic [7:0] status;
        sck_fall_cyc = cyc;
        if (frame_open && fb.size() > 0 && fb[0] == 8'h05 && nbits >= 8) begin
            idx = nbits - 8;
            status = {6'b0, 1'b1, ((idx / 8) < wip_polls)};
            miso = status[7 - (idx % 8)];
        end
    end

    task automatic process_frame();
        int flen, ncmp;
        logic [7:0] e;
        logic [23:0] base;
        if (exp_flen.size() == 0) begin
            check("unexpected_frame", 1'b0, fb.size(), 0);
            return;
        end
        flen = exp_flen.pop_front();
        ncmp = exp_ncmp.pop_front();
        check("frame_len", fb.size() == flen, fb.size(), flen);
        for (int i = 0; i < ncmp; i++) begin
            e = exp_bytes.pop_front();
            if (i < fb.size()) check("frame_byte", fb[i] == e, fb[i], e);
            else               check("frame_byte_missing", 1'b0, i, ncmp);
        end
        $display("frame: op=%02h len=%0d", (fb.size() > 0) ? fb[0] : 8'h00, fb.size());
        if (fb.size() == 1 && fb[0] == 8'h06) wel = 1'b1;
        if (fb.size() > 4 && fb[0] == 8'h02 && wel) begin
            base = {fb[1], fb[2], fb[3]};
            for (int i = 4; i < fb.size(); i++)
                fmem[int'({base[23:8], 8'(base[7:0] + 8'(i - 4))})] = fb[i];
            wel = 1'b0;
        end
    endtask

    always @(posedge cs_n) begin
        if (frame_open) begin
            frame_open = 1'b0;
            cs_rise_cyc = cyc;
            if (!ignore_frame) begin
                check("cs_hold", nbits == 0 || (cyc - sck_fall_cyc) >= 2, cyc - sck_fall_cyc, 2);
                check("frame_whole_bytes", nbits % 8 == 0, nbits, 0);
                process_frame();
            end
        end
    end

    // ---------------- handshake count and done monitor ----------------
    int hs_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) if (rst_n && din_valid && din_ready) hs_cnt++;

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (exp_err_q.size() == 0) check("unexpected_done", 1'b0, err, 0);
            else check("done_err", err == exp_err_q.pop_front(), err, !err);
            check("busy_at_done", busy == 1'b0, busy, 0);
            check("frames_all_seen", exp_flen.size() == 0, exp_flen.size(), 0);
            $display("done: err=%0b", err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        din = b;
        din_valid = 1'b1;
        while (!din_ready && t < 400) begin @(negedge clk); t++; end
        if (t >= 400) check("din_handshake_timeout", 1'b0, t, 400);
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic run_op(input logic [23:0] a, input int n, input int wp,
                          input int stall_at, input int stall_len, input bit poke_start);
        bit bad;
        int nstat, d0, hs0, f0, t, mem_bad;
        bit stall_ok;
        bad = (n == 0) || (n > 256) || ((int'(a[7:0]) + n) > 256);
        wip_polls = wp;
        $display("op: addr=%06h num=%0d wip_polls=%0d", a, n, wp);
        if (!bad) begin
            exp_flen.push_back(1); exp_ncmp.push_back(1); exp_bytes.push_back(8'h06);
            exp_flen.push_back(4 + n); exp_ncmp.push_back(4 + n);
            exp_bytes.push_back(8'h02);
            exp_bytes.push_back(a[23:16]); exp_bytes.push_back(a[15:8]); exp_bytes.push_back(a[7:0]);
            for (int i = 0; i < n; i++) begin
                exp_bytes.push_back(tx_data[i]);
                ref_mem[int'(a) + i] = tx_data[i];
            end
            nstat = (wp < POLL_MAX) ? wp + 1 : POLL_MAX;
            exp_flen.push_back(1 + nstat); exp_ncmp.push_back(1); exp_bytes.push_back(8'h05);
            exp_err_q.push_back(wp >= POLL_MAX);
        end else begin
            exp_err_q.push_back(1'b1);
        end
        d0 = done_cnt; hs0 = hs_cnt; f0 = frames_opened;
        @(negedge clk);
        addr = a; byte_num = n[8:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy == 1'b1, busy, 1);
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                if (i == stall_at) begin
                    t = 0;
                    while (!din_ready && t < 400) begin @(negedge clk); t++; end
                    stall_ok = 1'b1;
                    repeat (stall_len) begin
                        @(negedge clk);
                        if (sck !== 1'b0 || cs_n !== 1'b0 || din_ready !== 1'b1) stall_ok = 1'b0;
                    end
                    check("stall_bus_held", stall_ok, {sck, cs_n, din_ready}, 3'b001);
                end else begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                send_byte(tx_data[i]);
                if (poke_start && i == n / 2) begin
                    addr = 24'hFFFFFF; byte_num = 9'd0; start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 3000) begin @(negedge clk); t++; end
        check("done_seen", done_cnt == d0 + 1, done_cnt - d0, 1);
        if (bad) begin
            check("reject_latency", t <= 3, t, 3);
            check("no_cs_on_reject", frames_opened == f0, frames_opened - f0, 0);
        end else begin
            check("handshakes", (hs_cnt - hs0) == n, hs_cnt - hs0, n);
            mem_bad = 0;
            for (int i = 0; i < n; i++) begin
                if (!fmem.exists(int'(a) + i) || fmem[int'(a) + i] !== ref_mem[int'(a) + i]) mem_bad++;
            end
            check("flash_mem", mem_bad == 0, mem_bad, 0);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic fill_case1();
        tx_data.delete();
        tx_data.push_back(8'h11); tx_data.push_back(8'h22);
        tx_data.push_back(8'h33); tx_data.push_back(8'h44);
    endtask

    task automatic fill_random(input int n);
        tx_data.delete();
        for (int i = 0; i < n; i++) tx_data.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=%0d required=0", 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, off, d0;
        logic [23:0] a;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n == 1'b1, cs_n, 1);
        check("rst_sck", sck == 1'b0, sck, 0);
        check("rst_mosi", mosi == 1'b0, mosi, 0);
        check("rst_din_ready", din_ready == 1'b0, din_ready, 0);
        check("rst_busy_done_err", {busy, done, err} == 3'b000, {busy, done, err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fill_case1();
        run_op(24'h000100, 4, 3, -1, 0, 1'b0);
        run_op(24'h000100, 4, 3, 2, 50, 1'b0);
        run_op(24'h000100, 0, 0, -1, 0, 1'b0);
        run_op(24'h0000F0, 32, 0, -1, 0, 1'b0);
        fill_random(256);
        run_op(24'h123400, 256, 1, -1, 0, 1'b0);
        fill_random(2);
        run_op(24'h00AB10, 2, 1000, -1, 0, 1'b0);

        // reset in the middle of the data phase
        $display("op: reset during PP_DATA");
        fill_random(8);
        exp_flen.push_back(1); exp_ncmp.push_back(1); exp_bytes.push_back(8'h06);
        d0 = done_cnt;
        @(negedge clk);
        addr = 24'h000200; byte_num = 9'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(tx_data[i]);
        repeat (5) @(negedge clk);
        ignore_frame = 1'b1;
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", cs_n == 1'b1, cs_n, 1);
        check("abort_sck", sck == 1'b0, sck, 0);
        check("abort_busy", busy == 1'b0, busy, 0);
        exp_flen.delete(); exp_ncmp.delete(); exp_bytes.delete(); exp_err_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ignore_frame = 1'b0;
        check("abort_no_done", done_cnt == d0, done_cnt - d0, 0);
        check("abort_no_program", !fmem.exists(32'h200), fmem.exists(32'h200), 0);
        repeat (2) @(negedge clk);
        fill_case1();
        run_op(24'h000100, 4, 3, -1, 0, 1'b0);

        // randomized operations
        for (int k = 0; k < 8; k++) begin
            off = $urandom_range(0, 255);
            a = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'(off)};
            if (k == 5) n = 257 - off + $urandom_range(0, 3);
            else        n = $urandom_range(1, ((256 - off) < 40) ? (256 - off) : 40);
            fill_random(n);
            run_op(a, n, $urandom_range(0, 5), -1, 0, k == 2);
        end

        check("queues_drained", exp_flen.size() + exp_err_q.size() == 0,
              exp_flen.size() + exp_err_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
